// File: rtl/acs_scheduler.sv
// Scheduler for one shared ACS unit across the 4 states of a K=3 rate-1/2 Viterbi decoder.
// It owns the path-metric bank, sequences the ACS per state, normalizes, and emits survivor words.
module acs_scheduler #(
  parameter int unsigned PM_W    = 7,
  parameter int unsigned PM_INIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic            sym_valid,
  input  logic [1:0]      sym_data,
  output logic            sym_ready,
  output logic            acs_input_sig,
  output logic [1:0]      acs_self_state,
  output logic [1:0]      acs_data_recv,
  output logic [1:0]      acs_addr_in_1,
  output logic [1:0]      acs_addr_in_2,
  output logic [PM_W-1:0] acs_pm_in1,
  output logic [PM_W-1:0] acs_pm_in2,
  input  logic [PM_W-1:0] acs_pm_out,
  input  logic [1:0]      acs_addr_out,
  input  logic            acs_data_rdy,
  input  logic            acs_dec_out,
  output logic            surv_valid,
  output logic [7:0]      surv_data,
  output logic [3:0]      surv_dec,
  input  logic            surv_ready,
  output logic [1:0]      best_state,
  output logic [15:0]     sym_count
);

  localparam logic [PM_W-1:0] PM_INIT_V = PM_W'(PM_INIT);

  typedef enum logic [1:0] {IDLE, RUN, NORM, OUT} state_t;

  state_t          state;
  logic [1:0]      idx;
  logic [1:0]      sym_lat;
  logic [PM_W-1:0] pm     [4];
  logic [PM_W-1:0] new_pm [4];
  logic [7:0]      surv_acc;
  logic [3:0]      dec_acc;
  logic            acs_err;

  logic            accept;
  logic [1:0]      nxt_idx;
  logic [PM_W-1:0] nxt_pm1;
  logic [PM_W-1:0] nxt_pm2;
  logic [PM_W-1:0] pm_min;
  logic [1:0]      pm_arg;

  assign accept = (state == IDLE) && sym_ready && sym_valid;

  // Next ACS drive; a frame_start on the accept cycle uses the initial metrics directly.
  always_comb begin
    nxt_idx = (state == RUN) ? 2'(idx + 2'd1) : 2'd0;
    nxt_pm1 = pm[{nxt_idx[0], 1'b0}];
    nxt_pm2 = pm[{nxt_idx[0], 1'b1}];
    if (state == IDLE && frame_start) begin
      nxt_pm1 = nxt_idx[0] ? PM_INIT_V : '0;
      nxt_pm2 = PM_INIT_V;
    end
  end

  // Minimum of the fresh metrics; strict compare keeps the lowest index on ties.
  always_comb begin
    pm_min = new_pm[0];
    pm_arg = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (new_pm[i] < pm_min) begin
        pm_min = new_pm[i];
        pm_arg = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      sym_lat        <= '0;
      surv_acc       <= '0;
      dec_acc        <= '0;
      acs_err        <= 1'b0;
      sym_ready      <= 1'b0;
      acs_input_sig  <= 1'b0;
      acs_self_state <= '0;
      acs_data_recv  <= '0;
      acs_addr_in_1  <= '0;
      acs_addr_in_2  <= '0;
      acs_pm_in1     <= '0;
      acs_pm_in2     <= '0;
      surv_valid     <= 1'b0;
      surv_data      <= '0;
      surv_dec       <= '0;
      best_state     <= '0;
      sym_count      <= '0;
      for (int i = 0; i < 4; i++) begin
        pm[i]     <= (i == 0) ? '0 : PM_INIT_V;
        new_pm[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          sym_ready <= 1'b1;
          if (frame_start) begin
            sym_count <= '0;
            for (int i = 0; i < 4; i++) pm[i] <= (i == 0) ? '0 : PM_INIT_V;
          end
          if (accept) begin
            sym_ready      <= 1'b0;
            sym_lat        <= sym_data;
            idx            <= nxt_idx;
            surv_acc       <= '0;
            dec_acc        <= '0;
            acs_input_sig  <= 1'b1;
            acs_self_state <= nxt_idx;
            acs_data_recv  <= sym_data;
            acs_addr_in_1  <= {nxt_idx[0], 1'b0};
            acs_addr_in_2  <= {nxt_idx[0], 1'b1};
            acs_pm_in1     <= nxt_pm1;
            acs_pm_in2     <= nxt_pm2;
            state          <= RUN;
          end
        end
        RUN: begin
          if (acs_data_rdy) begin
            new_pm[idx]               <= acs_pm_out;
            surv_acc[{idx, 1'b0} +: 2] <= acs_addr_out;
            dec_acc[idx]              <= acs_dec_out;
          end else begin
            new_pm[idx] <= '1;
            acs_err     <= 1'b1;
          end
          if (idx == 2'd3) begin
            acs_input_sig  <= 1'b0;
            acs_self_state <= '0;
            acs_data_recv  <= '0;
            acs_addr_in_1  <= '0;
            acs_addr_in_2  <= '0;
            acs_pm_in1     <= '0;
            acs_pm_in2     <= '0;
            state          <= NORM;
          end else begin
            idx            <= nxt_idx;
            acs_self_state <= nxt_idx;
            acs_data_recv  <= sym_lat;
            acs_addr_in_1  <= {nxt_idx[0], 1'b0};
            acs_addr_in_2  <= {nxt_idx[0], 1'b1};
            acs_pm_in1     <= nxt_pm1;
            acs_pm_in2     <= nxt_pm2;
          end
        end
        NORM: begin
          for (int i = 0; i < 4; i++) pm[i] <= new_pm[i] - pm_min;
          best_state <= pm_arg;
          sym_count  <= sym_count + 16'd1;
          surv_data  <= surv_acc;
          surv_dec   <= dec_acc;
          surv_valid <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (surv_ready) begin
            surv_valid <= 1'b0;
            sym_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A missing ACS result during RUN poisons the metrics and latches this flag.
  a_acs_result_present: assert property (@(posedge clk) disable iff (rst) !acs_err);

endmodule

// File: tb/tb_acs_scheduler.sv
// Bench for acs_scheduler: acts as the combinational ACS and scoreboards ACS drives and survivor words.
module tb_acs_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       sym_valid;
  logic [1:0] sym_data;
  logic       sym_ready;
  logic       acs_input_sig;
  logic [1:0] acs_self_state;
  logic [1:0] acs_data_recv;
  logic [1:0] acs_addr_in_1;
  logic [1:0] acs_addr_in_2;
  logic [6:0] acs_pm_in1;
  logic [6:0] acs_pm_in2;
  logic [6:0] acs_pm_out;
  logic [1:0] acs_addr_out;
  logic       acs_data_rdy;
  logic       acs_dec_out;
  logic       surv_valid;
  logic [7:0] surv_data;
  logic [3:0] surv_dec;
  logic       surv_ready;
  logic [1:0] best_state;
  logic [15:0] sym_count;

  always #5 clk = ~clk;

  acs_scheduler dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .sym_valid(sym_valid),
    .sym_data(sym_data), .sym_ready(sym_ready), .acs_input_sig(acs_input_sig),
    .acs_self_state(acs_self_state), .acs_data_recv(acs_data_recv),
    .acs_addr_in_1(acs_addr_in_1), .acs_addr_in_2(acs_addr_in_2),
    .acs_pm_in1(acs_pm_in1), .acs_pm_in2(acs_pm_in2), .acs_pm_out(acs_pm_out),
    .acs_addr_out(acs_addr_out), .acs_data_rdy(acs_data_rdy), .acs_dec_out(acs_dec_out),
    .surv_valid(surv_valid), .surv_data(surv_data), .surv_dec(surv_dec),
    .surv_ready(surv_ready), .best_state(best_state), .sym_count(sym_count)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] a1;
    logic [1:0] a2;
    logic [6:0] p1;
    logic [6:0] p2;
    logic [1:0] d;
  } acs_t;

  typedef struct packed {
    logic [7:0]  surv;
    logic [3:0]  dec;
    logic [1:0]  best;
    logic [15:0] cnt;
  } exp_t;

  acs_t acs_q[$];
  exp_t surv_q[$];
  int   mpm[4];
  logic [15:0] mcnt;
  int   n_checks = 0;
  int   n_err = 0;

  // Hamming distance between the received symbol and the (7,5) encoder output on edge p->s.
  function automatic logic [1:0] bm(input logic [1:0] p, input logic [1:0] s, input logic [1:0] sym);
    logic [1:0] o;
    logic [1:0] x;
    o = {s[1] ^ p[1] ^ p[0], s[1] ^ p[0]};
    x = o ^ sym;
    return {1'b0, x[0]} + {1'b0, x[1]};
  endfunction

  // ACS unit: add-compare-select, the second predecessor wins a tie.
  logic [7:0] m1_c, m2_c;
  always_comb begin
    m1_c = {1'b0, acs_pm_in1} + 8'(bm(acs_addr_in_1, acs_self_state, acs_data_recv));
    m2_c = {1'b0, acs_pm_in2} + 8'(bm(acs_addr_in_2, acs_self_state, acs_data_recv));
    acs_pm_out   = (m1_c < m2_c) ? 7'(m1_c) : 7'(m2_c);
    acs_addr_out = (m1_c < m2_c) ? acs_addr_in_1 : acs_addr_in_2;
    acs_data_rdy = acs_input_sig;
    acs_dec_out  = acs_self_state[1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mpm[0] = 0; mpm[1] = 16; mpm[2] = 16; mpm[3] = 16;
    mcnt = 16'd0;
  endtask

  task automatic model_symbol(input logic [1:0] sym, output exp_t e);
    int np[4];
    int m1, m2, mn;
    logic [1:0] st, a1, a2;
    acs_t a;
    e = '0;
    for (int s = 0; s < 4; s++) begin
      st = 2'(s);
      a1 = {st[0], 1'b0};
      a2 = {st[0], 1'b1};
      a = '{st: st, a1: a1, a2: a2, p1: 7'(mpm[a1]), p2: 7'(mpm[a2]), d: sym};
      acs_q.push_back(a);
      m1 = mpm[a1] + int'(bm(a1, st, sym));
      m2 = mpm[a2] + int'(bm(a2, st, sym));
      if (m1 < m2) begin np[s] = m1; e.surv[2*s +: 2] = a1; end
      else         begin np[s] = m2; e.surv[2*s +: 2] = a2; end
      e.dec[s] = st[1];
    end
    mn = np[0];
    for (int s = 1; s < 4; s++) if (np[s] < mn) begin mn = np[s]; e.best = 2'(s); end
    for (int s = 0; s < 4; s++) mpm[s] = np[s] - mn;
    mcnt = mcnt + 16'd1;
    e.cnt = mcnt;
  endtask

  // Monitor: pops an expectation whenever the DUT drives the ACS or hands over a survivor word.
  always @(negedge clk) begin
    acs_t a;
    exp_t e;
    if (!rst) begin
      if (acs_input_sig) begin
        if (acs_q.size() == 0) check("acs_unexpected", 32'(acs_input_sig), 32'd0);
        else begin
          a = acs_q.pop_front();
          check("acs_drive", 32'({acs_self_state, acs_addr_in_1, acs_addr_in_2,
                                  acs_pm_in1, acs_pm_in2, acs_data_recv}), 32'(a));
        end
      end
      if (surv_valid && surv_ready) begin
        if (surv_q.size() == 0) check("surv_unexpected", 32'(surv_valid), 32'd0);
        else begin
          e = surv_q.pop_front();
          check("surv_data", 32'(surv_data), 32'(e.surv));
          check("surv_dec", 32'(surv_dec), 32'(e.dec));
          check("best_state", 32'(best_state), 32'(e.best));
          check("sym_count", 32'(sym_count), 32'(e.cnt));
        end
      end
    end
  end

  // Issues one symbol from a negedge, pushes expectations, and checks the 6-cycle latency.
  task automatic send_sym(input logic [1:0] sym, input logic fs, input logic use_hand, input exp_t hand);
    exp_t e;
    int t;
    int cyc;
    t = 0;
    @(negedge clk);
    while (!sym_ready && t < 50) begin @(negedge clk); t++; end
    check("sym_ready_wait", 32'(sym_ready), 32'd1);
    if (sym_ready) begin
      if (fs) model_reset();
      model_symbol(sym, e);
      if (use_hand) e = hand;
      surv_q.push_back(e);
      sym_valid = 1'b1; sym_data = sym; frame_start = fs;
      @(posedge clk); #1;
      sym_valid = 1'b0; frame_start = 1'b0;
      cyc = 1;
      while (!surv_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
      check("latency", 32'(cyc), 32'd6);
    end
  endtask

  initial begin
    exp_t stall_e;
    logic [1:0] seq [4];
    int t, cyc, last, n;

    rst = 1'b1; frame_start = 1'b0; sym_valid = 1'b0; sym_data = 2'b00; surv_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", 32'({surv_valid, sym_ready, acs_input_sig, surv_data, surv_dec, best_state}), 32'd0);
    check("rst_count", 32'(sym_count), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Hand-computed directed sequence from the initial metrics.
    send_sym(2'b00, 1'b1, 1'b1, {8'hCC, 4'hC, 2'd0, 16'd1});
    send_sym(2'b01, 1'b0, 1'b1, {8'h88, 4'hC, 2'd0, 16'd2});
    send_sym(2'b11, 1'b0, 1'b1, {8'h88, 4'hC, 2'd2, 16'd3});
    send_sym(2'b10, 1'b0, 1'b1, {8'hD9, 4'hC, 2'd1, 16'd4});
    send_sym(2'b11, 1'b0, 1'b1, {8'hDD, 4'hC, 2'd0, 16'd5});

    // frame_start alone in IDLE clears the count and metrics.
    t = 0;
    @(negedge clk);
    while (!sym_ready && t < 50) begin @(negedge clk); t++; end
    frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    model_reset();
    @(negedge clk);
    check("fs_idle_count", 32'(sym_count), 32'd0);
    send_sym(2'b00, 1'b0, 1'b1, {8'hCC, 4'hC, 2'd0, 16'd1});

    // Stall in OUT; stray sym_valid and frame_start must be ignored.
    @(posedge clk); #1 surv_ready = 1'b0;
    send_sym(2'b01, 1'b0, 1'b0, '0);
    stall_e = surv_q[surv_q.size()-1];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(surv_valid), 32'd1);
      check("stall_data", 32'({surv_data, surv_dec}), 32'({stall_e.surv, stall_e.dec}));
      check("stall_ready", 32'(sym_ready), 32'd0);
      check("acs_idle", 32'({acs_input_sig, acs_self_state, acs_addr_in_1, acs_addr_in_2,
                             acs_pm_in1, acs_pm_in2, acs_data_recv}), 32'd0);
      sym_valid   = (i == 3);
      frame_start = (i == 6);
    end
    sym_valid = 1'b0; frame_start = 1'b0;
    @(posedge clk); #1 surv_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_ready", 32'({sym_ready, surv_valid}), 32'b10);
    send_sym(2'b10, 1'b0, 1'b0, '0);

    // Reset during RUN index 2 aborts the symbol.
    t = 0;
    @(negedge clk);
    while (!sym_ready && t < 50) begin @(negedge clk); t++; end
    model_symbol(2'b10, stall_e);
    surv_q.push_back(stall_e);
    sym_valid = 1'b1; sym_data = 2'b10;
    @(posedge clk); #1 sym_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!(acs_input_sig && acs_self_state == 2'd2) && t < 20);
    check("rst_run_idx", 32'({acs_input_sig, acs_self_state}), 32'b110);
    rst = 1'b1;
    @(posedge clk); #1;
    acs_q.delete();
    surv_q.delete();
    @(negedge clk);
    check("rst_run_out", 32'({surv_valid, acs_input_sig, sym_ready}), 32'd0);
    check("rst_run_count", 32'(sym_count), 32'd0);
    rst = 1'b0;
    model_reset();
    send_sym(2'b11, 1'b0, 1'b1, {8'hCC, 4'hC, 2'd2, 16'd1});

    // Back-to-back sym_valid: exactly one accept every 7 cycles.
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b00; seq[3] = 2'b11;
    cyc = 0; last = -1; n = 0;
    while (n < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      sym_data = seq[n];
      sym_valid = 1'b1;
      if (sym_ready) begin
        model_symbol(seq[n], stall_e);
        surv_q.push_back(stall_e);
        if (last >= 0) check("accept_period", 32'(cyc - last), 32'd7);
        last = cyc;
        n++;
      end
    end
    @(posedge clk); #1 sym_valid = 1'b0;
    check("stream_accepts", 32'(n), 32'd4);

    // Random symbols against the reference trellis model.
    for (int i = 0; i < 200; i++) send_sym(2'($urandom_range(0, 3)), 1'b0, 1'b0, '0);

    t = 0;
    while ((acs_q.size() != 0 || surv_q.size() != 0) && t < 100) begin @(negedge clk); t++; end
    check("drain", 32'(acs_q.size() + surv_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/acs_scheduler.md
Name: acs_scheduler

Overview:
- Time-multiplexes one ACS unit across the 4 trellis states of the K=3, rate-1/2 pipelined Viterbi decoder.
- For each received 2-bit symbol it holds the path-metric (PM) bank, drives the ACS ports for one state per cycle and captures the results.
- After all 4 states it normalizes the metrics and hands an 8-bit survivor word to the traceback stage over a valid/ready handshake.

Parameters:
- PM_W, 7, path-metric width; matches the ACS PM ports.
- PM_INIT, 16, initial metric of states 1..3 at frame start; state 0 starts at 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  reinitialize PM bank and symbol counter; sampled only in IDLE
- sym_valid  in  1  received symbol valid
- sym_data  in  2  received symbol
- sym_ready  out  1  scheduler can accept a symbol
- acs_input_sig  out  1  ACS enable
- acs_self_state  out  2  state being computed
- acs_data_recv  out  2  latched symbol
- acs_addr_in_1  out  2  predecessor 1 = {self_state[0],1'b0}
- acs_addr_in_2  out  2  predecessor 2 = {self_state[0],1'b1}
- acs_pm_in1  out  PM_W  PM[acs_addr_in_1]
- acs_pm_in2  out  PM_W  PM[acs_addr_in_2]
- acs_pm_out  in  PM_W  selected metric
- acs_addr_out  in  2  selected predecessor
- acs_data_rdy  in  1  ACS result valid
- acs_dec_out  in  1  decoded bit for the state
- surv_valid  out  1  survivor word valid
- surv_data  out  8  surv_data[2s+1:2s] = predecessor chosen for state s
- surv_dec  out  4  surv_dec[s] = acs_dec_out for state s
- surv_ready  in  1  traceback accepts the word
- best_state  out  2  state with minimum normalized PM; lowest index wins a tie
- sym_count  out  16  symbols fully processed since frame start, wraps at 0xFFFF->0

Behaviour:
- Reset state:
  - FSM goes to IDLE; all outputs are 0.
  - PM bank = {0, PM_INIT, PM_INIT, PM_INIT}.
  - The ACS is combinational; the scheduler owns all timing.
- FSM states: IDLE, RUN, NORM, OUT.
- IDLE:
  - sym_ready=1.
  - On sym_valid: latch sym_data, set the state index to 0, go to RUN.
  - If frame_start is also high, reinitialize PM and clear sym_count first, so this symbol uses the initial metrics.
  - frame_start without sym_valid reinitializes PM/count and stays in IDLE.
- RUN:
  - Lasts exactly 4 cycles, index 0..3.
  - Drives acs_input_sig=1, acs_self_state=index, predecessor addresses and their PMs from the current bank.
  - Each cycle, if acs_data_rdy=1, captures acs_pm_out into new_pm[index], acs_addr_out into the surv_data slot and acs_dec_out into surv_dec[index].
  - acs_data_rdy=0 during RUN is an error: set a sticky internal flag visible to assertions, store PM as all-ones.
  - The current bank is not modified during RUN.
  - After index 3, go to NORM.
- NORM (1 cycle):
  - min = minimum of new_pm[0..3]; PM[s] = new_pm[s] - min, so at least one metric is 0.
  - best_state = argmin.
  - sym_count increments, wrapping.
  - Go to OUT.
- OUT:
  - surv_valid=1; surv_data and surv_dec are held stable until surv_ready=1.
  - On surv_ready: surv_valid drops next cycle and the FSM returns to IDLE.
  - surv_ready low stalls indefinitely; sym_ready stays 0.
- Outside RUN: acs_input_sig=0 and other acs_* outputs are 0.
- Latency: from the symbol accept edge, surv_valid rises 6 cycles later (4 RUN + 1 NORM + entry to OUT). Throughput is at most 1 symbol per 7 cycles.
- frame_start outside IDLE is ignored.
- Arithmetic and widths:
  - Subtraction is unsigned and cannot underflow.
  - After normalization the PM spread is at most 2*(K-1)=4 plus PM_INIT, so overflow is impossible while PM_INIT <= 2^PM_W - 8.
- Reset mid-operation (any state) aborts the symbol:
  - surv_valid drops in the next cycle.
  - PM bank and sym_count return to reset values.
  - The partial survivor word is discarded.

Test Plan:
- Reset, then frame_start+sym_valid with sym_data=2'b00 -> acs_self_state sequence 0,1,2,3 on cycles 1-4 with addr_in pairs (00,01),(10,11),(00,01),(10,11). Six cycles after accept: surv_valid=1, surv_data=8'hCC, surv_dec=4'b1100, PM={0,17,2,17}, best_state=0, sym_count=1.
- Hold surv_ready=0 for 10 cycles -> surv_valid and surv_data stable, sym_ready=0, a sym_valid pulse ignored. Then surv_ready=1 -> IDLE next cycle with sym_ready=1.
- Tie between PMs -> best_state is the lowest index. After each NORM, min(PM)=0 across 1000 random symbols; never exceeds 2^PM_W-1.
- Assert rst during RUN index 2 -> next cycle FSM in IDLE, surv_valid=0, PM={0,16,16,16}, sym_count=0.
- frame_start pulsed during OUT -> no effect. frame_start alone in IDLE after 5 symbols -> sym_count=0, PM reset.
- Streaming 65536 symbols -> sym_count wraps to 0. Back-to-back sym_valid with surv_ready=1 -> exactly one accept per 7 cycles.
